// File: rtl/pc_fetch_unit.sv
// Program-counter and instruction-fetch stage for the 8-bit RISC CPU.
// The PC feeds an external ripple adder (add_a/add_b); every PC increment is
// taken from add_sum. Instructions come in over a req/ack memory handshake
// and are handed to decode over a valid/ready handshake.
module pc_fetch_unit #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter logic [7:0] STEP     = 8'h01
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [7:0] add_a,
  output logic [7:0] add_b,
  input  logic [7:0] add_sum,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic       mem_ack,
  input  logic [7:0] mem_rdata,
  output logic [7:0] ir,
  output logic       ir_valid,
  input  logic       ir_ready,
  input  logic       skip,
  input  logic       br_valid,
  input  logic [7:0] br_target,
  output logic [7:0] pc
);

  typedef enum logic [1:0] {StIdle, StFetch, StHold} state_e;

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;

  // State, PC and instruction register; reset drops mem_req/ir_valid at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      ir_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state logic; a branch overrides everything, including a same-cycle ack.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    if (br_valid) begin
      // Going through idle gives the one-cycle gap on mem_req before refetch.
      pc_d    = br_target;
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (en) state_d = StFetch;
        end
        StFetch: begin
          if (mem_ack) begin
            ir_d    = mem_rdata;
            pc_d    = add_sum;
            state_d = StHold;
          end
        end
        StHold: begin
          if (ir_ready) begin
            if (skip) pc_d = add_sum;
            state_d = en ? StFetch : StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs are decoded from registered state only.
  always_comb begin
    add_a    = pc_q;
    add_b    = STEP;
    mem_req  = (state_q == StFetch);
    mem_addr = pc_q;
    ir       = ir_q;
    ir_valid = (state_q == StHold);
    pc       = pc_q;
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios, randomized traffic checked
// against a transaction-level model, async reset and PC wrap-around.
module tb_pc_fetch_unit;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] add_a, add_b, add_sum;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic [7:0] ir;
  logic       ir_valid;
  logic       ir_ready;
  logic       skip;
  logic       br_valid;
  logic [7:0] br_target;
  logic [7:0] pc;

  // Second instance reset to 8'hFF to exercise the wrap through the adder.
  logic       w_en;
  logic [7:0] w_add_a, w_add_b, w_add_sum;
  logic       w_req;
  logic [7:0] w_addr;
  logic [7:0] w_ir;
  logic       w_ir_valid;
  logic [7:0] w_pc;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] mem [256];

  // Reference model: PC, last fetched byte, and whether a request or an
  // instruction is outstanding (neither means idle).
  logic [7:0] m_pc;
  logic [7:0] m_ir;
  bit         m_req;
  bit         m_has_ir;

  // The external 8-bit adder, carry discarded.
  assign add_sum   = add_a + add_b;
  assign w_add_sum = w_add_a + w_add_b;

  pc_fetch_unit u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_sum  (add_sum),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .ir       (ir),
    .ir_valid (ir_valid),
    .ir_ready (ir_ready),
    .skip     (skip),
    .br_valid (br_valid),
    .br_target(br_target),
    .pc       (pc)
  );

  pc_fetch_unit #(
    .RESET_PC(8'hFF),
    .STEP    (8'h01)
  ) u_wrap (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (w_en),
    .add_a    (w_add_a),
    .add_b    (w_add_b),
    .add_sum  (w_add_sum),
    .mem_req  (w_req),
    .mem_addr (w_addr),
    .mem_ack  (w_req),
    .mem_rdata(8'h5A),
    .ir       (w_ir),
    .ir_valid (w_ir_valid),
    .ir_ready (1'b1),
    .skip     (1'b0),
    .br_valid (1'b0),
    .br_target(8'h00),
    .pc       (w_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_pc     = 8'h00;
    m_ir     = 8'h00;
    m_req    = 1'b0;
    m_has_ir = 1'b0;
  endtask

  // One clock of the instruction-stream rules, using the inputs just applied.
  task automatic model_update();
    if (br_valid) begin
      m_pc     = br_target;
      m_req    = 1'b0;
      m_has_ir = 1'b0;
    end else if (m_req) begin
      if (mem_ack) begin
        m_ir     = mem[m_pc];
        m_pc     = m_pc + 8'h01;
        m_req    = 1'b0;
        m_has_ir = 1'b1;
      end
    end else if (m_has_ir) begin
      if (ir_ready) begin
        m_has_ir = 1'b0;
        if (skip) m_pc = m_pc + 8'h01;
        m_req = en;
      end
    end else begin
      m_req = en;
    end
  endtask

  task automatic compare();
    check8("pc", pc, m_pc);
    check8("add_a", add_a, m_pc);
    check8("add_b", add_b, 8'h01);
    check8("mem_req", {7'd0, mem_req}, {7'd0, m_req});
    check8("ir_valid", {7'd0, ir_valid}, {7'd0, m_has_ir});
    if (m_req) check8("mem_addr", mem_addr, m_pc);
    if (m_has_ir) check8("ir", ir, m_ir);
  endtask

  // Check at the falling edge, drive inputs, then advance model on the rising edge.
  task automatic step(input bit e, input bit rdy, input bit sk, input bit br,
                      input logic [7:0] tgt, input bit ack);
    @(negedge clk);
    compare();
    en        = e;
    ir_ready  = rdy;
    skip      = sk;
    br_valid  = br;
    br_target = tgt;
    mem_ack   = ack;
    mem_rdata = ack ? mem[mem_addr] : 8'($urandom);
    @(posedge clk);
    model_update();
  endtask

  initial begin
    int         nreq;
    bit         have;
    logic [7:0] a0, a1, pc_after;

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hA0;
    mem[1] = 8'hA1;

    rst_n = 1'b0; en = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00;
    ir_ready = 1'b0; skip = 1'b0; br_valid = 1'b0; br_target = 8'h00;
    w_en = 1'b0;
    model_reset();

    #12;
    check8("rst_pc", pc, 8'h00);
    check8("rst_ir", ir, 8'h00);
    check8("rst_ir_valid", {7'd0, ir_valid}, 8'd0);
    check8("rst_mem_req", {7'd0, mem_req}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Linear fetch with a decode stall.
    step(1, 1, 0, 0, 8'h00, 0); #1;
    check8("lin_req0", {7'd0, mem_req}, 8'd1);
    check8("lin_addr0", mem_addr, 8'h00);
    step(1, 1, 0, 0, 8'h00, 1); #1;
    check8("lin_ir0", ir, 8'hA0);
    check8("lin_pc1", pc, 8'h01);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0, 8'h00, 0); #1;
      check8("stall_ir", ir, 8'hA0);
      check8("stall_pc", pc, 8'h01);
      check8("stall_req", {7'd0, mem_req}, 8'd0);
    end
    step(1, 1, 0, 0, 8'h00, 0); #1;
    check8("lin_addr1", mem_addr, 8'h01);
    step(1, 1, 0, 0, 8'h00, 1); #1;
    check8("lin_ir1", ir, 8'hA1);
    check8("lin_pc2", pc, 8'h02);

    // Branch arriving together with the ack of address 05.
    step(1, 1, 0, 1, 8'h05, 0);
    step(1, 1, 0, 0, 8'h00, 0); #1;
    check8("br_fetch05", mem_addr, 8'h05);
    step(1, 1, 0, 1, 8'h40, 1); #1;
    check8("br_pc40", pc, 8'h40);
    check8("br_ir_valid", {7'd0, ir_valid}, 8'd0);
    check8("br_gap_req", {7'd0, mem_req}, 8'd0);
    step(1, 1, 0, 0, 8'h00, 0); #1;
    check8("br_addr40", mem_addr, 8'h40);
    step(1, 1, 0, 0, 8'h00, 1); #1;
    check8("br_pc41", pc, 8'h41);

    // Skip ignored under a branch, then honoured at pc 10.
    step(1, 1, 1, 1, 8'h10, 0); #1;
    check8("br_skip_pc", pc, 8'h10);
    step(1, 1, 0, 0, 8'h00, 0);
    step(1, 1, 0, 0, 8'h00, 1); #1;
    check8("skip_pc11", pc, 8'h11);
    step(1, 1, 1, 0, 8'h00, 0); #1;
    check8("skip_addr12", mem_addr, 8'h12);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit e, rdy, sk, br, ack;
      e   = ($urandom_range(99, 0) < 85);
      rdy = ($urandom_range(99, 0) < 60);
      sk  = ($urandom_range(99, 0) < 25);
      br  = ($urandom_range(99, 0) < 5);
      ack = mem_req ? ($urandom_range(1, 0) == 1) : ($urandom_range(19, 0) == 0);
      step(e, rdy, sk, br, 8'($urandom), ack);
    end

    // Async reset while a fetch is outstanding.
    for (int i = 0; i < 2; i++) step(1, 1, 0, 0, 8'h00, 0);
    #1;
    check8("pre_rst_req", {7'd0, mem_req}, 8'd1);
    en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check8("arst_req", {7'd0, mem_req}, 8'd0);
    check8("arst_ir_valid", {7'd0, ir_valid}, 8'd0);
    check8("arst_pc", pc, 8'h00);
    model_reset();
    mem_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check8("arst_hold_pc", pc, 8'h00);
    check8("arst_hold_req", {7'd0, mem_req}, 8'd0);

    // Release with a stale ack still high; the wrap instance runs meanwhile.
    w_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    nreq = 0; have = 1'b0; a0 = 8'h55; a1 = 8'h55; pc_after = 8'h55;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (nreq == 2 && !have) begin
        pc_after = w_pc;
        have     = 1'b1;
      end
      if (w_req && nreq < 2) begin
        if (nreq == 0) a0 = w_addr;
        else a1 = w_addr;
        nreq++;
      end
      check8("late_ack_req", {7'd0, mem_req}, 8'd0);
      check8("late_ack_pc", pc, 8'h00);
    end
    check8("wrap_addr0", a0, 8'hFF);
    check8("wrap_addr1", a1, 8'h00);
    check8("wrap_pc", pc_after, 8'h01);
    w_en = 1'b0;

    for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 8'h00, 1);
    @(negedge clk);
    compare();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and instruction-fetch stage of the 8-bit RISC CPU.
- Holds the PC and drives the PC operands into the 8-bit ripple adder, which sits directly downstream. Captures the adder's sum as the next PC.
- Fetches instruction bytes from program memory over a req/ack handshake and presents them to decode over a valid/ready handshake.
- Supports branch redirect and skip-next-instruction.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- STEP, 8'h01, increment applied per fetched instruction; driven on add_b.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  fetch enable; low parks the unit in IDLE after the current handshake.
- add_a  out  8  PC operand to the adder; always equals pc.
- add_b  out  8  step operand to the adder; always equals STEP.
- add_sum  in  8  combinational sum from the adder (carry discarded).
- mem_req  out  1  program-memory read request.
- mem_addr  out  8  read address; equals pc while mem_req=1.
- mem_ack  in  1  memory read completes this cycle.
- mem_rdata  in  8  instruction byte; valid when mem_ack=1.
- ir  out  8  instruction register to decode.
- ir_valid  out  1  ir holds an unconsumed instruction.
- ir_ready  in  1  decode accepts ir this cycle.
- skip  in  1  sampled with the ir handshake; skip the following instruction.
- br_valid  in  1  branch redirect request (1-cycle pulse).
- br_target  in  8  branch destination.
- pc  out  8  current program counter.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pc=RESET_PC, ir=8'h00, ir_valid=0, mem_req=0, state=IDLE.
  - Asserting reset mid-fetch drops mem_req immediately; any later mem_ack is ignored.
- States: IDLE, FETCH, HOLD.
- IDLE: mem_req=0, ir_valid=0. If en=1, go to FETCH next cycle.
- FETCH:
  - mem_req=1 and mem_addr=pc, held stable until mem_ack.
  - On mem_ack: ir<=mem_rdata, pc<=add_sum (pc+STEP), ir_valid<=1, go to HOLD.
  - mem_req deasserts in the cycle after the ack.
  - If en falls in FETCH, the request still completes.
- HOLD:
  - ir_valid=1; ir and pc are held until ir_ready=1.
  - On handshake (ir_valid and ir_ready): ir_valid<=0. If skip=1, pc<=add_sum, so the PC advances by STEP once more.
  - Next state is FETCH if en=1, otherwise IDLE.
- Fetch latency: with ack in the cycle after req, one instruction is issued every 3 cycles (FETCH, ack, HOLD+ready). Back-to-back throughput is not required.
- Branch (br_valid=1) has priority over everything in any state:
  - pc<=br_target and ir_valid<=0; any instruction in ir is discarded.
  - A mem_ack arriving in the same cycle is discarded.
  - mem_req drops for one cycle, then next state is FETCH if en=1, else IDLE.
  - skip is ignored in a branch cycle.
- Arithmetic: the PC is 8 bits. 8'hFF+1 wraps to 8'h00 via the adder; no overflow flag. Skip from 8'hFF lands on 8'h00, then 8'h01.
- add_a and add_b are purely combinational from pc and the parameter. The unit never computes pc+STEP internally; all increments come from add_sum.
- No combinational path from mem_ack, ir_ready or br_valid to any output except through registered state.

Test Plan:
- Reset and linear fetch: release rst_n, en=1, memory returns 8'hA0 at 0, 8'hA1 at 1, ack 1 cycle after req, ir_ready=1 → ir sequence A0, A1; pc 00→01→02; mem_addr 00, 01.
- Decode stall: ir_ready=0 for 5 cycles in HOLD → ir=8'hA0 and pc=8'h01 held, mem_req=0 throughout; fetch of address 01 starts one cycle after ready rises.
- Branch mid-fetch: br_valid=1, br_target=8'h40 in the same cycle as mem_ack for address 05 → rdata discarded, ir_valid=0, next mem_addr=8'h40; pc=8'h41 after that ack.
- Skip: ir at pc=8'h10 (pc reg 8'h11), handshake with skip=1 → next mem_addr=8'h12.
- Wrap: RESET_PC=8'hFF → first fetch at FF, second at 00; pc=8'h01 after the second ack.
- Async reset during FETCH (mem_req=1) → mem_req, ir_valid and pc return to reset values without a clock edge; a late mem_ack causes no state change.
